issue_queue_multi: RTL
======================

Name: issue_queue_multi

Overview:
- Parametrised, age-ordered issue queue (reservation station) between the rename/dispatch stage and NUM_FU functional units in the out-of-order core.
- Holds up to DEPTH renamed instructions and captures operand values from NUM_WB writeback/forward buses.
- Each cycle, selects the oldest operand-ready entries, one per free functional unit, and sends them to the units through registered issue ports.
- Generalises the fixed three-unit queue: configurable depth, unit count and writeback count, a valid/ready dispatch handshake, flush support and oldest-first select.

Parameters:
- DEPTH, 16, number of entries (power of 2, at least 4).
- NUM_FU, 3, number of issue ports / functional units.
- NUM_WB, 3, number of wakeup/forward buses.
- PREG_W, 6, physical register tag width.
- XLEN, 32, operand and immediate width.
- ROB_W, 6, ROB index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept an entry this cycle.
- disp_rd  in  PREG_W  destination tag.
- disp_rs1, disp_rs2  in  PREG_W each  source tags.
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  source value already valid.
- disp_rs1_val, disp_rs2_val  in  XLEN each  source values, meaningful when the matching rdy bit is 1.
- disp_opcode  in  7  instruction opcode.
- disp_funct3  in  3  funct3 field.
- disp_funct7  in  7  funct7 field.
- disp_imm  in  XLEN  immediate.
- disp_rob  in  ROB_W  ROB index.
- wb_valid  in  NUM_WB  per-bus wakeup valid.
- wb_tag  in  NUM_WB*PREG_W  flattened tags; bus i occupies bits [i*PREG_W +: PREG_W].
- wb_val  in  NUM_WB*XLEN  flattened values.
- fu_ready  in  NUM_FU  unit k can accept an instruction this cycle.
- issue_valid  out  NUM_FU  registered issue strobe per unit.
- issue_payload  out  NUM_FU*P  flattened payloads, P = PREG_W+3*XLEN+17+ROB_W.
  - Packing, MSB to LSB: {rob, opcode, funct7, funct3, imm, rs2_val, rs1_val, rd}.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, reset_n=0): all entries invalid; issue_valid=0; issue_payload=0; count=0; disp_ready=1.
- disp_ready = (count != DEPTH). Entries freed by issue in the same cycle are not counted, so the queue reports full conservatively.
- Dispatch handshake: an entry is written when disp_valid && disp_ready && !flush.
  - It goes into the lowest-index free entry.
  - It receives an age stamp. Ordering is kept with an age matrix or an equivalent strictly-ordered scheme.
- Source tag 0 is always ready; a wakeup on tag 0 is ignored.
- Wakeup of a resident entry: for each bus i with wb_valid[i] and wb_tag[i] equal to a non-ready source tag, the value is captured and the source marked ready at the edge.
  - If several buses match the same tag, the lowest bus index wins.
  - Both sources of one entry may wake in the same cycle.
- Wakeup of the dispatching entry: a dispatching source with rdy=0 whose tag matches a wakeup bus in the same cycle is captured as ready. This prevents missed wakeups.
- Eligibility: an entry is eligible when it is valid and both sources are ready as of the start of the cycle.
- Select: order the eligible entries oldest first. Assign them in that order to units k = 0..NUM_FU-1 that have fu_ready[k]=1, skipping units that are not ready. At most NUM_FU issues per cycle.
- Issue: at the edge, each selected entry's payload is registered into issue_payload[k], issue_valid[k] is set to 1, and the entry is freed.
  - Units with no selected entry drive issue_valid[k]=0; their payload holds its previous value.
- Latency: an entry dispatched ready at edge N is eligible in cycle N+1 and its issue_valid is visible after edge N+1. A resident entry woken at edge N issues after edge N+1 at the earliest.
- Count update: count += dispatched − issued, every cycle.
- Flush: at the edge, all entries are invalidated, issue_valid=0 and count=0. Flush takes priority over a same-cycle dispatch and issue.
- Dispatch while full: there is no write and no state change. A stall of any length must not corrupt the entry contents.

Optional Feature:
- Macro: IQ_WAKEUP_BYPASS_EN.
- Defined: a resident entry whose last missing source is woken in cycle N is eligible in cycle N itself. The wb_val is muxed directly into the issued payload, which saves one cycle of wakeup-to-issue latency.
- Undefined: wakeup-to-issue is at least one cycle, as specified above.
- Age ordering and the lowest-bus-index priority rule are identical in both builds.

Test Plan:
- Reset with defaults: after reset_n rises, count=0, disp_ready=1, issue_valid=3'b000.
- Dispatch rd=10, rs1=5, rs2=5, both rdy=0, rob=20. Then assert wb_valid[0]=1, wb_tag[0]=5, wb_val[0]=32'hA5A5A5A5.
  - Required: issue_valid[0]=1 two edges after the wakeup.
  - Required payload: rs1_val = rs2_val = A5A5A5A5, rd=10, rob=20.
- Dispatch 16 entries with sources never ready: count=16 and disp_ready=0; a 17th request is dropped. Wake all entries: the oldest three issue on units 0..2 on the first issue edge, and disp_ready returns to 1.
- Age order: dispatch A (rob=1) then B (rob=2) with fu_ready=3'b010, waking both in the same cycle. Required: unit 1 issues A first, then B on the next cycle.
- Same-cycle wakeup on dispatch: dispatch rs1=7 with rdy=0 while wb_tag[1]=7 and wb_val[1]=5A5A5A5A. Required: the entry issues with rs1_val=5A5A5A5A, no hang.
- Flush with 5 valid entries plus a concurrent dispatch: next cycle count=0, issue_valid=0, and no later issue of any flushed entry.

Source files
------------

// File: rtl/issue_queue_multi.sv
// -----------------------------------------------------------------------------
// issue_queue_multi
//
// Age-ordered issue queue (reservation station) sitting between rename/dispatch
// and NUM_FU functional units. Holds up to DEPTH renamed instructions, captures
// operand values from NUM_WB writeback buses, and each cycle sends the oldest
// operand-ready entries to the free units through registered issue ports.
//
// Optional feature macro: IQ_WAKEUP_BYPASS_EN
//   defined   : an entry whose last missing source is woken this cycle is
//               eligible this cycle; the bus value is muxed into the payload.
//   undefined : wakeup-to-issue takes at least one extra cycle.
//
// Ports:
//   clk, reset_n      clock / asynchronous active-low reset
//   flush             synchronous clear of all entries
//   disp_*            dispatch request (valid/ready handshake) and fields
//   wb_valid/tag/val  flattened wakeup/forward buses, bus i at [i*W +: W]
//   fu_ready          per-unit accept
//   issue_valid       registered issue strobe per unit
//   issue_payload     flattened payloads, {rob,opcode,funct7,funct3,imm,
//                     rs2_val,rs1_val,rd} per unit
//   count             number of occupied entries
// -----------------------------------------------------------------------------
module issue_queue_multi #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 3,
  parameter int PREG_W = 6,
  parameter int XLEN   = 32,
  parameter int ROB_W  = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PREG_W-1:0]          disp_rd,
  input  logic [PREG_W-1:0]          disp_rs1,
  input  logic [PREG_W-1:0]          disp_rs2,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [XLEN-1:0]            disp_rs1_val,
  input  logic [XLEN-1:0]            disp_rs2_val,
  input  logic [6:0]                 disp_opcode,
  input  logic [2:0]                 disp_funct3,
  input  logic [6:0]                 disp_funct7,
  input  logic [XLEN-1:0]            disp_imm,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
  input  logic [NUM_WB*XLEN-1:0]     wb_val,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          issue_valid,
  output logic [NUM_FU*(PREG_W+3*XLEN+17+ROB_W)-1:0] issue_payload,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int P     = PREG_W + 3*XLEN + 17 + ROB_W;

  // entry storage
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [PREG_W-1:0] rd_q [DEPTH], rd_d [DEPTH];
  logic [PREG_W-1:0] rs1_q [DEPTH], rs1_d [DEPTH];
  logic [PREG_W-1:0] rs2_q [DEPTH], rs2_d [DEPTH];
  logic [XLEN-1:0]   rs1_val_q [DEPTH], rs1_val_d [DEPTH];
  logic [XLEN-1:0]   rs2_val_q [DEPTH], rs2_val_d [DEPTH];
  logic [6:0]        opcode_q [DEPTH], opcode_d [DEPTH];
  logic [2:0]        funct3_q [DEPTH], funct3_d [DEPTH];
  logic [6:0]        funct7_q [DEPTH], funct7_d [DEPTH];
  logic [XLEN-1:0]   imm_q [DEPTH], imm_d [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH], rob_d [DEPTH];
  // older_q[i][j] = 1 means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];

  logic [NUM_FU-1:0]   issue_valid_q, issue_valid_d;
  logic [NUM_FU*P-1:0] issue_payload_q, issue_payload_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // combinational helpers
  logic              disp_fire;
  logic [IDX_W-1:0]  free_idx;
  logic [DEPTH-1:0]  rs1_hit, rs2_hit, rs1_ok, rs2_ok, elig, issue_mask;
  logic [XLEN-1:0]   rs1_wbv [DEPTH], rs2_wbv [DEPTH];
  logic [XLEN-1:0]   rs1_eff [DEPTH], rs2_eff [DEPTH];
  logic [CNT_W-1:0]  rank [DEPTH];
  logic [CNT_W-1:0]  slot [NUM_FU];
  logic [NUM_FU-1:0] sel_valid;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [CNT_W-1:0]  n_issued;
  logic [XLEN:0]     disp_lk1, disp_lk2;

  // Search the wakeup buses for a tag; returns {hit, value}. Iterating from
  // the highest bus down lets the lowest-index match win. Tag 0 never matches.
  function automatic logic [XLEN:0] wb_lookup(input logic [PREG_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int b = NUM_WB-1; b >= 0; b--) begin
      if (wb_valid[b] && (tag != '0) && (wb_tag[b*PREG_W +: PREG_W] == tag))
        res = {1'b1, wb_val[b*XLEN +: XLEN]};
    end
    return res;
  endfunction

  assign disp_ready    = (count_q != CNT_W'(DEPTH));
  assign disp_fire     = disp_valid && disp_ready && !flush;
  assign issue_valid   = issue_valid_q;
  assign issue_payload = issue_payload_q;
  assign count         = count_q;

  // wakeup matching, eligibility and operand values seen by the selector
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {rs1_hit[i], rs1_wbv[i]} = wb_lookup(rs1_q[i]);
      {rs2_hit[i], rs2_wbv[i]} = wb_lookup(rs2_q[i]);
`ifdef IQ_WAKEUP_BYPASS_EN
      rs1_ok[i]  = rs1_rdy_q[i] | rs1_hit[i];
      rs2_ok[i]  = rs2_rdy_q[i] | rs2_hit[i];
      rs1_eff[i] = rs1_rdy_q[i] ? rs1_val_q[i] : rs1_wbv[i];
      rs2_eff[i] = rs2_rdy_q[i] ? rs2_val_q[i] : rs2_wbv[i];
`else
      rs1_ok[i]  = rs1_rdy_q[i];
      rs2_ok[i]  = rs2_rdy_q[i];
      rs1_eff[i] = rs1_val_q[i];
      rs2_eff[i] = rs2_val_q[i];
`endif
      elig[i] = valid_q[i] & rs1_ok[i] & rs2_ok[i];
    end
    disp_lk1 = wb_lookup(disp_rs1);
    disp_lk2 = wb_lookup(disp_rs2);
  end

  // Oldest-first select: an eligible entry's rank is the number of older
  // eligible entries; unit k takes the entry whose rank equals the number of
  // ready units below k, so busy units are skipped without losing order.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i) rank[i] = rank[i] + CNT_W'(elig[j] & older_q[j][i]);
      end
    end
    for (int k = 0; k < NUM_FU; k++) begin
      slot[k] = '0;
      for (int m = 0; m < k; m++) slot[k] = slot[k] + CNT_W'(fu_ready[m]);
    end
    sel_valid  = '0;
    issue_mask = '0;
    n_issued   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel_idx[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (fu_ready[k] && elig[i] && (rank[i] == slot[k])) begin
          sel_valid[k] = 1'b1;
          sel_idx[k]   = IDX_W'(i);
          issue_mask[i] = 1'b1;
        end
      end
      n_issued = n_issued + CNT_W'(sel_valid[k]);
    end
  end

  // Entry next state: resident wakeup, free on issue, dispatch write, flush.
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]      = rd_q[i];
      rs1_d[i]     = rs1_q[i];
      rs2_d[i]     = rs2_q[i];
      rs1_val_d[i] = rs1_val_q[i];
      rs2_val_d[i] = rs2_val_q[i];
      opcode_d[i]  = opcode_q[i];
      funct3_d[i]  = funct3_q[i];
      funct7_d[i]  = funct7_q[i];
      imm_d[i]     = imm_q[i];
      rob_d[i]     = rob_q[i];
      older_d[i]   = older_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rs1_rdy_q[i] && rs1_hit[i]) begin
        rs1_rdy_d[i] = 1'b1;
        rs1_val_d[i] = rs1_wbv[i];
      end
      if (valid_q[i] && !rs2_rdy_q[i] && rs2_hit[i]) begin
        rs2_rdy_d[i] = 1'b1;
        rs2_val_d[i] = rs2_wbv[i];
      end
      if (issue_mask[i]) valid_d[i] = 1'b0;
    end

    if (disp_fire) begin
      valid_d[free_idx]   = 1'b1;
      rd_d[free_idx]      = disp_rd;
      rs1_d[free_idx]     = disp_rs1;
      rs2_d[free_idx]     = disp_rs2;
      rs1_rdy_d[free_idx] = disp_rs1_rdy | (disp_rs1 == '0) | disp_lk1[XLEN];
      rs2_rdy_d[free_idx] = disp_rs2_rdy | (disp_rs2 == '0) | disp_lk2[XLEN];
      rs1_val_d[free_idx] = disp_rs1_rdy ? disp_rs1_val :
                            (disp_lk1[XLEN] ? disp_lk1[XLEN-1:0] : '0);
      rs2_val_d[free_idx] = disp_rs2_rdy ? disp_rs2_val :
                            (disp_lk2[XLEN] ? disp_lk2[XLEN-1:0] : '0);
      opcode_d[free_idx]  = disp_opcode;
      funct3_d[free_idx]  = disp_funct3;
      funct7_d[free_idx]  = disp_funct7;
      imm_d[free_idx]     = disp_imm;
      rob_d[free_idx]     = disp_rob;
      // the new entry is younger than every other slot
      older_d[free_idx]   = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end

    if (flush) valid_d = '0;
  end

  // issue registers and occupancy count
  always_comb begin
    issue_valid_d   = '0;
    issue_payload_d = issue_payload_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (sel_valid[k] && !flush) begin
        issue_valid_d[k] = 1'b1;
        issue_payload_d[k*P +: P] = {rob_q[sel_idx[k]], opcode_q[sel_idx[k]],
                                     funct7_q[sel_idx[k]], funct3_q[sel_idx[k]],
                                     imm_q[sel_idx[k]], rs2_eff[sel_idx[k]],
                                     rs1_eff[sel_idx[k]], rd_q[sel_idx[k]]};
      end
    end
    count_d = flush ? '0 : (count_q + CNT_W'(disp_fire) - n_issued);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q         <= '0;
      rs1_rdy_q       <= '0;
      rs2_rdy_q       <= '0;
      issue_valid_q   <= '0;
      issue_payload_q <= '0;
      count_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]      <= '0;
        rs1_q[i]     <= '0;
        rs2_q[i]     <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
        opcode_q[i]  <= '0;
        funct3_q[i]  <= '0;
        funct7_q[i]  <= '0;
        imm_q[i]     <= '0;
        rob_q[i]     <= '0;
        older_q[i]   <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      rs1_rdy_q       <= rs1_rdy_d;
      rs2_rdy_q       <= rs2_rdy_d;
      issue_valid_q   <= issue_valid_d;
      issue_payload_q <= issue_payload_d;
      count_q         <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]      <= rd_d[i];
        rs1_q[i]     <= rs1_d[i];
        rs2_q[i]     <= rs2_d[i];
        rs1_val_q[i] <= rs1_val_d[i];
        rs2_val_q[i] <= rs2_val_d[i];
        opcode_q[i]  <= opcode_d[i];
        funct3_q[i]  <= funct3_d[i];
        funct7_q[i]  <= funct7_d[i];
        imm_q[i]     <= imm_d[i];
        rob_q[i]     <= rob_d[i];
        older_q[i]   <= older_d[i];
      end
    end
  end

endmodule
